// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI register-write initiator.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package spi_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        HOLD  = 2'd2,
        GAP   = 2'd3
    } spi_state_t;

    localparam int FRAME_BITS = 16;
    localparam int ADDR_W     = 7;
    localparam int DATA_W     = 8;
    localparam int WRITE_BIT  = 15;

    localparam logic [ADDR_W-1:0] EN_OUT_LO = 7'h00;
    localparam logic [ADDR_W-1:0] EN_OUT_HI = 7'h01;
    localparam logic [ADDR_W-1:0] EN_PWM_LO = 7'h02;
    localparam logic [ADDR_W-1:0] EN_PWM_HI = 7'h03;
    localparam logic [ADDR_W-1:0] PWM_DUTY  = 7'h04;

    function automatic logic [FRAME_BITS-1:0] make_frame(
        input logic              w,
        input logic [ADDR_W-1:0] addr,
        input logic [DATA_W-1:0] data
    );
        return {w, addr, data};
    endfunction

endpackage

// File: rtl/spi_clk_gen.sv
// Half-period timer: pulses phase_tick on the last cycle of every CLK_DIV-cycle phase.
// Latency: first tick CLK_DIV cycles after start rises; counter held at zero while start is low.
// Backpressure: none; free-running while start is high.
module spi_clk_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    output logic phase_tick
);

    localparam int               CNT_W = $clog2(CLK_DIV);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (!start || cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign phase_tick = start && (cnt == LAST);

endmodule

// File: rtl/spi_controller.sv
// Mode-0 SPI initiator sending 16-bit {W,addr,data} frames; optional readback via `SPI_CTRL_READ_EN.
// Latency: nCS low from the cycle after accept for 33*CLK_DIV cycles, done one cycle later, ready again after CLK_DIV more.
// Backpressure: req_ready is high only in IDLE; requests at any other time are ignored.
module spi_controller
    import spi_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_data,
`ifdef SPI_CTRL_READ_EN
    input  logic              req_we,
    input  logic              cipo,
    output logic [DATA_W-1:0] rsp_data,
`endif
    output logic              sclk,
    output logic              copi,
    output logic              ncs,
    output logic              busy,
    output logic              done
);

    if (CLK_DIV < 2) begin : g_bad_div
        $error("spi_controller: CLK_DIV must be at least 2");
    end

    spi_state_t            state, state_nxt;
    logic [FRAME_BITS-1:0] shreg, shreg_nxt;
    logic [4:0]            bit_cnt, bit_nxt;
    logic                  sclk_nxt, copi_nxt, ncs_nxt, done_nxt;
    logic                  phase_tick;
    logic                  wr_bit;
    logic [FRAME_BITS-1:0] frame;

`ifdef SPI_CTRL_READ_EN
    logic [DATA_W-1:0] rx_sh, rx_nxt, rsp_nxt;
    assign wr_bit = req_we;
`else
    assign wr_bit = 1'b1;
`endif

    assign frame = make_frame(wr_bit, req_addr, req_data);

    spi_clk_gen #(
        .CLK_DIV(CLK_DIV)
    ) u_clk_gen (
        .clk       (clk),
        .rst       (rst),
        .start     (state != IDLE),
        .phase_tick(phase_tick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            shreg     <= '0;
            bit_cnt   <= '0;
            sclk      <= 1'b0;
            copi      <= 1'b0;
            ncs       <= 1'b1;
            done      <= 1'b0;
            busy      <= 1'b0;
            req_ready <= 1'b0;
`ifdef SPI_CTRL_READ_EN
            rx_sh     <= '0;
            rsp_data  <= '0;
`endif
        end else begin
            state     <= state_nxt;
            shreg     <= shreg_nxt;
            bit_cnt   <= bit_nxt;
            sclk      <= sclk_nxt;
            copi      <= copi_nxt;
            ncs       <= ncs_nxt;
            done      <= done_nxt;
            busy      <= (state_nxt != IDLE);
            req_ready <= (state_nxt == IDLE);
`ifdef SPI_CTRL_READ_EN
            rx_sh     <= rx_nxt;
            rsp_data  <= rsp_nxt;
`endif
        end
    end

    always_comb begin
        state_nxt = state;
        shreg_nxt = shreg;
        bit_nxt   = bit_cnt;
        sclk_nxt  = sclk;
        copi_nxt  = copi;
        ncs_nxt   = ncs;
        done_nxt  = 1'b0;
`ifdef SPI_CTRL_READ_EN
        rx_nxt    = rx_sh;
        rsp_nxt   = rsp_data;
`endif
        case (state)
            IDLE: begin
                // req_ready already implies IDLE; outputs switch on the accept edge itself
                if (req_valid && req_ready) begin
                    state_nxt = SHIFT;
                    shreg_nxt = frame;
                    bit_nxt   = '0;
                    ncs_nxt   = 1'b0;
                    sclk_nxt  = 1'b0;
                    copi_nxt  = frame[WRITE_BIT];
                end
            end
            SHIFT: begin
                if (phase_tick) begin
                    if (!sclk) begin
                        sclk_nxt = 1'b1;
`ifdef SPI_CTRL_READ_EN
                        if (bit_cnt >= 5'd8) begin
                            rx_nxt = {rx_sh[DATA_W-2:0], cipo};
                        end
`endif
                    end else begin
                        sclk_nxt = 1'b0;
                        if (bit_cnt == 5'(FRAME_BITS - 1)) begin
                            state_nxt = HOLD;
                        end else begin
                            bit_nxt   = bit_cnt + 5'd1;
                            shreg_nxt = {shreg[FRAME_BITS-2:0], 1'b0};
                            copi_nxt  = shreg[WRITE_BIT-1];
                        end
                    end
                end
            end
            HOLD: begin
                if (phase_tick) begin
                    state_nxt = GAP;
                    ncs_nxt   = 1'b1;
                    copi_nxt  = 1'b0;
                    done_nxt  = 1'b1;
`ifdef SPI_CTRL_READ_EN
                    rsp_nxt   = rx_sh;
`endif
                end
            end
            GAP: begin
                if (phase_tick) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule
